hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the RISC-V core, sitting between the IF/ID and ID/Ex pipeline registers and the data-memory handshake. It does three jobs:
- stalls the front end for multi-cycle data-memory accesses, with a per-access timeout;
- detects load-use hazards and inserts a single bubble;
- flushes the wrong-path instructions on a taken branch.

It also counts stall cycles for performance monitoring. Register-index width, memory mode and timeout are parameters.

---
 rtl/hazard_ctrl_unit.sv | 113 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: memory-wait stalls with timeout, load-use bubbles,
// taken-branch flushes and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
   parameter int REG_ADDR_W  = 4,
   parameter int MEM_WAIT_EN = 1,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
   input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
   input  logic [REG_ADDR_W-1:0] ID_Ex_rd,
   input  logic                  ID_Ex_MemRead,
   input  logic                  ID_Ex_MemWrite,
   input  logic                  mem_ready,
   input  logic                  branch_taken,
   output logic                  PC_write,
   output logic                  IF_ID_write,
   output logic                  ID_Ex_enable,
   output logic                  IF_ID_flush,
   output logic                  ID_Ex_flush,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ACK_WAIT = 3'd1;
   localparam logic [2:0] S_BUSY     = 3'd2;
   localparam logic [2:0] S_DONE     = 3'd3;
   localparam logic [2:0] S_ERR      = 3'd4;

   localparam int              TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_inc;
   logic            to_hit;
   logic            mem_op;
   logic            mem_stall;
   logic            load_use;

   assign mem_op = ID_Ex_MemRead | ID_Ex_MemWrite;
   assign to_inc = to_cnt + 1'b1;
   // Timeout fires on the cycle whose increment makes the count reach the limit.
   assign to_hit = (TIMEOUT_CYC != 0) && (to_inc == TO_LIM);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if ((MEM_WAIT_EN != 0) && mem_op) state_nxt = S_ACK_WAIT;
         S_ACK_WAIT: begin
            if (to_hit)          state_nxt = S_ERR;
            else if (!mem_ready) state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (mem_ready)       state_nxt = S_DONE;
            else if (to_hit)     state_nxt = S_ERR;
         end
         S_DONE:     state_nxt = S_IDLE;
         S_ERR:      state_nxt = S_ERR;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         to_cnt       <= '0;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_ACK_WAIT || state == S_BUSY)
            to_cnt <= to_inc;
         else if (state == S_IDLE || state == S_DONE)
            to_cnt <= '0;
         if (!PC_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign mem_stall = ((state == S_IDLE) && (MEM_WAIT_EN != 0) && mem_op)
                    || (state == S_ACK_WAIT) || (state == S_BUSY) || (state == S_ERR);

   assign load_use = ID_Ex_MemRead && (ID_Ex_rd != '0)
                   && ((ID_Ex_rd == IF_ID_rs1) || (ID_Ex_rd == IF_ID_rs2))
                   && ((state == S_IDLE) || (state == S_DONE));

   assign mem_timeout = (state == S_ERR);

   always_comb begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_Ex_enable = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_Ex_flush  = 1'b0;
      if (mem_stall) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_Ex_enable = 1'b0;
      end else if (branch_taken) begin
         IF_ID_flush  = 1'b1;
         ID_Ex_flush  = 1'b1;
      end else if (load_use) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_Ex_flush  = 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: one multi-cycle-memory instance and one single-cycle
// instance share stimulus; a scoreboard queue feeds a negedge monitor.
module tb_hazard_ctrl_unit;

   localparam int RW   = 4;
   localparam int TO   = 8;
   localparam int CW_M = 4;
   localparam int CW_S = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [RW-1:0] IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_Ex_rd = '0;
   logic          ID_Ex_MemRead = 1'b0, ID_Ex_MemWrite = 1'b0;
   logic          mem_ready = 1'b1, branch_taken = 1'b0;

   logic            pcw_m, ifw_m, ide_m, iff_m, idf_m, tmo_m;
   logic [CW_M-1:0] cnt_m;
   logic            pcw_s, ifw_s, ide_s, iff_s, idf_s, tmo_s;
   logic [CW_S-1:0] cnt_s;

   hazard_ctrl_unit #(.REG_ADDR_W(RW), .MEM_WAIT_EN(1), .TIMEOUT_CYC(TO), .CNT_W(CW_M)) dut_m (
      .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_Ex_rd(ID_Ex_rd),
      .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_MemWrite(ID_Ex_MemWrite), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .PC_write(pcw_m), .IF_ID_write(ifw_m), .ID_Ex_enable(ide_m),
      .IF_ID_flush(iff_m), .ID_Ex_flush(idf_m), .mem_timeout(tmo_m), .stall_cycles(cnt_m));

   hazard_ctrl_unit #(.REG_ADDR_W(RW), .MEM_WAIT_EN(0), .TIMEOUT_CYC(TO), .CNT_W(CW_S)) dut_s (
      .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_Ex_rd(ID_Ex_rd),
      .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_MemWrite(ID_Ex_MemWrite), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .PC_write(pcw_s), .IF_ID_write(ifw_s), .ID_Ex_enable(ide_s),
      .IF_ID_flush(iff_s), .ID_Ex_flush(idf_s), .mem_timeout(tmo_s), .stall_cycles(cnt_s));

   // Reference view of an access: in flight, accepted by memory, finishing, failed.
   typedef struct {
      bit active;
      bit accepted;
      bit finish;
      bit err;
      int elapsed;
      int cnt;
   } model_t;

   typedef struct {
      logic [5:0] ctl_m;
      int         cnt_m;
      logic [5:0] ctl_s;
      int         cnt_s;
      int         cyc;
   } exp_t;

   exp_t   sb[$];
   model_t mm, ms;
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   bit     push_en = 1'b0;

   // Returns {PC_write, IF_ID_write, ID_Ex_enable, IF_ID_flush, ID_Ex_flush, mem_timeout}.
   function automatic logic [5:0] model_ctl(model_t m, bit mw, bit mrd, bit mwr,
                                            int rd, int s1, int s2, bit br);
      bit idle, stall, luse;
      idle  = !m.active && !m.finish && !m.err;
      stall = m.err || m.active || (idle && mw && (mrd || mwr));
      luse  = (idle || m.finish) && mrd && (rd != 0) && (rd == s1 || rd == s2);
      if (stall)     return {5'b00000, m.err};
      else if (br)   return 6'b111110;
      else if (luse) return 6'b001010;
      else           return 6'b111000;
   endfunction

   function automatic model_t model_step(model_t m, bit mw, int cmax, bit pcw,
                                         bit r, bit mrd, bit mwr, bit mr);
      model_t n;
      bit     tmo;
      n = m;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      if (!pcw && n.cnt < cmax) n.cnt = n.cnt + 1;
      if (m.err) begin
      end else if (m.active) begin
         n.elapsed = m.elapsed + 1;
         tmo = (TO != 0) && (n.elapsed == TO);
         if (!m.accepted) begin
            if (tmo) begin n.err = 1; n.active = 0; end
            else if (!mr) n.accepted = 1;
         end else begin
            if (mr) begin n.active = 0; n.finish = 1; end
            else if (tmo) begin n.err = 1; n.active = 0; end
         end
      end else if (m.finish) begin
         n.finish = 0;
      end else if (mw && (mrd || mwr)) begin
         n.active = 1; n.accepted = 0; n.elapsed = 0;
      end
      return n;
   endfunction

   task automatic drive(bit r, bit mrd, bit mwr, int rd, int s1, int s2, bit mr, bit br);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ID_Ex_MemRead = mrd; ID_Ex_MemWrite = mwr;
      ID_Ex_rd = RW'(rd); IF_ID_rs1 = RW'(s1); IF_ID_rs2 = RW'(s2);
      mem_ready = mr; branch_taken = br;
      e.ctl_m = model_ctl(mm, 1'b1, mrd, mwr, rd, s1, s2, br);
      e.ctl_s = model_ctl(ms, 1'b0, mrd, mwr, rd, s1, s2, br);
      e.cnt_m = mm.cnt;
      e.cnt_s = ms.cnt;
      e.cyc   = cyc;
      if (push_en) sb.push_back(e);
      mm = model_step(mm, 1'b1, (1 << CW_M) - 1, e.ctl_m[5], r, mrd, mwr, mr);
      ms = model_step(ms, 1'b0, (1 << CW_S) - 1, e.ctl_s[5], r, mrd, mwr, mr);
      cyc++;
   endtask

   // Acceptance latency a (ready high as a glitch before the low phase), busy time b,
   // then the DONE cycle with the memory op still presented.
   task automatic mem_access(bit isrd, int a, int b, int rd, int s1, int s2, bit br);
      drive(0, isrd, !isrd, rd, s1, s2, 1, br);
      for (int i = 0; i < a - 1; i++) drive(0, isrd, !isrd, rd, s1, s2, 1, br);
      drive(0, isrd, !isrd, rd, s1, s2, 0, br);
      for (int i = 0; i < b - 1; i++) drive(0, isrd, !isrd, rd, s1, s2, 0, br);
      drive(0, isrd, !isrd, rd, s1, s2, 1, br);
      drive(0, isrd, !isrd, rd, s1, s2, 1, br);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({pcw_m, ifw_m, ide_m, iff_m, idf_m, tmo_m} !== e.ctl_m || 32'(cnt_m) != e.cnt_m) begin
               bad++;
               $display("FAIL mem_dut cyc=%0d ctl got=%b want=%b cnt got=%0d want=%0d",
                        e.cyc, {pcw_m, ifw_m, ide_m, iff_m, idf_m, tmo_m}, e.ctl_m, cnt_m, e.cnt_m);
            end
            total++;
            if ({pcw_s, ifw_s, ide_s, iff_s, idf_s, tmo_s} !== e.ctl_s || 32'(cnt_s) != e.cnt_s) begin
               bad++;
               $display("FAIL sc_dut cyc=%0d ctl got=%b want=%b cnt got=%0d want=%0d",
                        e.cyc, {pcw_s, ifw_s, ide_s, iff_s, idf_s, tmo_s}, e.ctl_s, cnt_s, e.cnt_s);
            end
         end
      end
   end

   initial begin : stimulus
      int mode, mrp;
      mm = '{default: 0};
      ms = '{default: 0};
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      push_en = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0);

      mem_access(1, 1, 4, 3, 1, 2, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      mem_access(1, 1, 1, 5, 0, 5, 0);
      mem_access(1, 1, 1, 0, 0, 0, 0);
      mem_access(0, 1, 1, 5, 0, 5, 0);
      mem_access(1, 2, 2, 5, 5, 1, 1);
      drive(0, 1, 0, 5, 0, 5, 1, 1);

      drive(1, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 12; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      mem_access(0, 1, 7, 0, 0, 0, 0);
      mem_access(0, 2, 7, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0);

      drive(0, 0, 1, 0, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0);

      mem_access(0, 4, 4, 0, 0, 0, 0);
      mem_access(0, 4, 4, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 2400; i++) begin
         mode = (i / 200) % 3;
         mrp  = (mode == 0) ? 50 : (mode == 1) ? 10 : 85;
         drive($urandom_range(0, 99) < 2,
               ($urandom % 4) == 0, ($urandom % 6) == 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom_range(0, 99) < mrp, $urandom_range(0, 99) < 15);
      end

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
